pulse_peak_detector: RTL and testbench
======================================

PULSE_PEAK_DETECTOR -- requirements
Module: pulse_peak_detector

Interface
REQ-001 Parameter: TS_W, 32, timestamp counter width.
REQ-002 Parameter: MAX_WIDTH, 1024, maximum cycles a pulse may stay above threshold before it is aborted.
REQ-003 Parameter: BL_SHIFT, 6, baseline averaging shift; used only when the baseline feature is compiled in.
REQ-004 Port: clk  input  1  clock; all logic on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-low reset.
REQ-006 Port: filter_data  input  SIZE_FILTER_DATA  unsigned shaped sample from the upstream trapezoidal filter, one per clk.
REQ-007 Port: threshold  input  SIZE_FILTER_DATA  trigger level; quasi-static.
REQ-008 Port: holdoff  input  8  dead-time cycles after each pulse.
REQ-009 Port: out_ready  input  1  consumer accepts the event.
REQ-010 Port: out_valid  output  1  event held in the output slot.
REQ-011 Port: out_amp  output  SIZE_FILTER_DATA  peak amplitude.
REQ-012 Port: out_ts  output  TS_W  timestamp of the peak sample.
REQ-013 Port: lost_cnt  output  16  events dropped; saturates at 0xFFFF.
REQ-014 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-015 A free-running TS_W counter increments every cycle and wraps to 0 at all-ones.
REQ-016 Effective sample e = filter_data - baseline, saturated at 0; baseline = 0 when the feature is compiled out.
REQ-017 FSM states: IDLE, ARMED, DEAD.
REQ-018 IDLE: e > threshold (strict) -> ARMED; max <= e, ts <= counter, width counter <= 0.
REQ-019 ARMED: e > max -> max <= e, ts <= counter; e == max does not update, so the first occurrence of a peak wins.
REQ-020 ARMED: e <= threshold -> emit event, then go to DEAD with dead counter <= holdoff.
REQ-021 ARMED: width counter reaching MAX_WIDTH -> no emit, lost_cnt +1, go to DEAD.
REQ-022 DEAD: dead counter decrements each cycle; go to IDLE only when it is 0 and e <= threshold; holdoff = 0 therefore gives a single DEAD cycle.
REQ-023 Emit loads out_amp/out_ts from max/ts and sets out_valid on the cycle after the first sample at or below threshold.
REQ-024 out_valid and out_ready both high -> slot freed that cycle.
REQ-025 Emit while the slot is occupied and not being freed that cycle -> event dropped, lost_cnt +1, outputs unchanged.
REQ-026 Emit in the same cycle the slot is freed -> new event loaded and out_valid stays 1.
REQ-027 out_amp/out_ts remain stable while out_valid is high and out_ready is low.
REQ-028 lost_cnt holds at 0xFFFF; it never wraps.

Reset
REQ-029 reset low at a clock edge -> state IDLE; counters, max, ts, out_amp, out_ts and lost_cnt 0; out_valid 0; busy 0; baseline 0.
REQ-030 A reset asserted mid-pulse or with a pending event discards that event without incrementing lost_cnt.

Configuration
REQ-031 Macro PEAK_DET_BASELINE_EN defined -> in IDLE only, baseline += (filter_data - baseline) >>> BL_SHIFT each cycle (signed, SIZE_FILTER_DATA+BL_SHIFT internal bits); baseline is frozen in ARMED and DEAD.
REQ-032 Macro PEAK_DET_BASELINE_EN undefined -> no baseline logic, e = filter_data.

Structure
REQ-033 Package peak_detector_parameters holds the state enum typedef, TS_W/MAX_WIDTH/BL_SHIFT defaults and the lost_cnt width; SIZE_FILTER_DATA comes from package_settings.
REQ-034 Baseline logic lives in sub-module peak_baseline_tracker, instantiated only under PEAK_DET_BASELINE_EN.

Verification
REQ-035 threshold=100, holdoff=4, pulse 0,50,150,300,250,90,0 with out_ready=1 -> one event, out_amp=300, out_ts = counter at the 300 sample, out_valid one cycle after the 90 sample.
REQ-036 Plateau 200,200,200 -> out_ts = cycle of the first 200.
REQ-037 out_ready=0, two separated pulses with peaks 300 and 400 -> out_amp stays 300, lost_cnt=1; out_ready=1 then frees the slot.
REQ-038 Sample held at 500 for MAX_WIDTH+5 cycles -> no event, lost_cnt=1, busy until the level drops and holdoff expires.
REQ-039 Second pulse starting 2 cycles after the first ends with holdoff=4 -> ignored, no event and no lost_cnt change.
REQ-040 Reset asserted while ARMED -> next cycle IDLE, out_valid=0, lost_cnt=0; with PEAK_DET_BASELINE_EN and constant input 1000, a 1040 pulse at threshold=30 is detected with out_amp near 40.

Source files
------------

// File: rtl/pulse_peak_detector_pkg.sv
// Shared settings and types for the pulse peak detector.
//
// package_settings         : data-path width of the shaped filter samples.
// peak_detector_parameters : detector state type, parameter defaults and
//                            the width of the dropped-event counter.

package package_settings;
  localparam int SIZE_FILTER_DATA = 16;
endpackage : package_settings

package peak_detector_parameters;
  localparam int TS_W_DEF      = 32;
  localparam int MAX_WIDTH_DEF = 1024;
  localparam int BL_SHIFT_DEF  = 6;
  localparam int LOST_W        = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DEAD  = 2'd2
  } state_t;
endpackage : peak_detector_parameters

// File: rtl/peak_baseline_tracker.sv
// Slow baseline estimator for the pulse peak detector.
//
// Exists only when PEAK_DET_BASELINE_EN is defined.
//
// Ports:
//   clk      in  rising-edge clock
//   reset    in  synchronous, active-low reset
//   enable   in  track the input this cycle (frozen otherwise)
//   sample   in  SIZE_FILTER_DATA-bit unsigned filter sample
//   baseline out SIZE_FILTER_DATA-bit integer part of the estimate
//
// The accumulator holds baseline scaled by 2**BL_SHIFT, so each update is
// baseline += (sample - baseline) >>> BL_SHIFT with the fractional bits
// retained. Without them, differences smaller than 2**BL_SHIFT would never
// move the estimate and it would settle well below a constant input.

`ifdef PEAK_DET_BASELINE_EN
module peak_baseline_tracker
  import package_settings::*;
#(
  parameter int BL_SHIFT = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [SIZE_FILTER_DATA-1:0] sample,
  output logic [SIZE_FILTER_DATA-1:0] baseline
);

  localparam int ACC_W = SIZE_FILTER_DATA + BL_SHIFT;

  // The accumulator never goes negative (each step removes at most 1/2**BL_SHIFT
  // of it), so it is stored unsigned; the difference is signed and
  // sign-extended before the add.
  logic [ACC_W-1:0]                acc;
  logic signed [SIZE_FILTER_DATA:0] diff;

  assign baseline = acc[ACC_W-1:BL_SHIFT];
  assign diff     = signed'({1'b0, sample}) - signed'({1'b0, baseline});

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + ACC_W'(diff);
    end
  end

endmodule : peak_baseline_tracker
`endif

// File: rtl/pulse_peak_detector.sv
// Pulse peak detector: finds the peak of each above-threshold pulse in a
// shaped sample stream and presents amplitude + timestamp in a one-deep
// valid/ready output slot.
//
// Build option: define PEAK_DET_BASELINE_EN to subtract a slowly tracked
// baseline (peak_baseline_tracker) from each sample before detection.
//
// Ports:
//   clk          in  rising-edge clock
//   reset        in  synchronous, active-low reset
//   filter_data  in  SIZE_FILTER_DATA unsigned sample, one per cycle
//   threshold    in  SIZE_FILTER_DATA trigger level (strictly above arms)
//   holdoff      in  8-bit dead time after each pulse
//   out_ready    in  consumer takes the event in the slot
//   out_valid    out slot holds an event
//   out_amp      out SIZE_FILTER_DATA peak amplitude
//   out_ts       out TS_W timestamp of the (first) peak sample
//   lost_cnt     out 16-bit saturating count of dropped/aborted events
//   busy         out detector is not IDLE

module pulse_peak_detector
  import package_settings::*;
  import peak_detector_parameters::*;
#(
  parameter int TS_W      = TS_W_DEF,
  parameter int MAX_WIDTH = MAX_WIDTH_DEF,
  parameter int BL_SHIFT  = BL_SHIFT_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SIZE_FILTER_DATA-1:0] filter_data,
  input  logic [SIZE_FILTER_DATA-1:0] threshold,
  input  logic [7:0]                  holdoff,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [SIZE_FILTER_DATA-1:0] out_amp,
  output logic [TS_W-1:0]             out_ts,
  output logic [LOST_W-1:0]           lost_cnt,
  output logic                        busy
);

  localparam int WIDTH_W = $clog2(MAX_WIDTH);

  state_t                      state;
  logic [TS_W-1:0]             ts_cnt;
  logic [SIZE_FILTER_DATA-1:0] peak;
  logic [TS_W-1:0]             peak_ts;
  logic [WIDTH_W-1:0]          width_cnt;
  logic [7:0]                  dead_cnt;
  logic [SIZE_FILTER_DATA-1:0] eff;

`ifdef PEAK_DET_BASELINE_EN
  logic [SIZE_FILTER_DATA-1:0] baseline;

  // Baseline follows the input only between pulses so a pulse cannot pull
  // the reference up under itself.
  peak_baseline_tracker #(
    .BL_SHIFT (BL_SHIFT)
  ) u_baseline (
    .clk      (clk),
    .reset    (reset),
    .enable   (state == IDLE),
    .sample   (filter_data),
    .baseline (baseline)
  );

  assign eff = (filter_data > baseline) ? filter_data - baseline : '0;
`else
  // BL_SHIFT only matters when the baseline tracker is built.
  logic unused_bl_shift;
  assign unused_bl_shift = ^BL_SHIFT;
  assign eff = filter_data;
`endif

  logic emit, abort, slot_free, drop;

  assign emit      = (state == ARMED) && (eff <= threshold);
  assign abort     = (state == ARMED) && !emit && (width_cnt == WIDTH_W'(MAX_WIDTH - 1));
  assign slot_free = out_valid && out_ready;
  // A pulse is lost when it is aborted, or when it completes while the slot
  // is still occupied and not being drained this cycle.
  assign drop      = abort || (emit && out_valid && !out_ready);
  assign busy      = (state != IDLE);

  // NOTE: all state here uses non-blocking assignments, so every branch reads
  // the pre-edge value of peak/out_valid/lost_cnt regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ts_cnt    <= '0;
      peak      <= '0;
      peak_ts   <= '0;
      width_cnt <= '0;
      dead_cnt  <= '0;
      out_valid <= 1'b0;
      out_amp   <= '0;
      out_ts    <= '0;
      lost_cnt  <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);

      unique case (state)
        IDLE: begin
          if (eff > threshold) begin
            state     <= ARMED;
            peak      <= eff;
            peak_ts   <= ts_cnt;
            width_cnt <= '0;
          end
        end
        ARMED: begin
          if (emit || abort) begin
            state    <= DEAD;
            dead_cnt <= holdoff;
          end else begin
            width_cnt <= width_cnt + WIDTH_W'(1);
            // Strictly greater: on a plateau the first sample keeps the stamp.
            if (eff > peak) begin
              peak    <= eff;
              peak_ts <= ts_cnt;
            end
          end
        end
        DEAD: begin
          if (dead_cnt != '0) begin
            dead_cnt <= dead_cnt - 8'd1;
          end else if (eff <= threshold) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Slot: a new event may be loaded in the same cycle the old one drains.
      if (emit && (!out_valid || out_ready)) begin
        out_valid <= 1'b1;
        out_amp   <= peak;
        out_ts    <= peak_ts;
      end else if (slot_free) begin
        out_valid <= 1'b0;
      end

      if (drop && (lost_cnt != '1)) begin
        lost_cnt <= lost_cnt + LOST_W'(1);
      end
    end
  end

endmodule : pulse_peak_detector

// File: tb/tb_pulse_peak_detector.sv
// Self-checking bench for pulse_peak_detector: directed pulses with
// hand-computed expectations plus a per-cycle comparison against a
// behavioural model of the detection rules.

module tb_pulse_peak_detector;
  import package_settings::*;
  import peak_detector_parameters::*;

  localparam int W    = SIZE_FILTER_DATA;
  localparam int MAXW = 1024;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [W-1:0]     filter_data = '0;
  logic [W-1:0]     threshold = 16'd100;
  logic [7:0]       holdoff = 8'd4;
  logic             out_ready = 1'b1;
  logic             out_valid;
  logic [W-1:0]     out_amp;
  logic [31:0]      out_ts;
  logic [LOST_W-1:0] lost_cnt;
  logic             busy;

  always #5 clk = ~clk;

  pulse_peak_detector #(
    .TS_W      (32),
    .MAX_WIDTH (MAXW),
    .BL_SHIFT  (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .filter_data (filter_data),
    .threshold   (threshold),
    .holdoff     (holdoff),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_amp     (out_amp),
    .out_ts      (out_ts),
    .lost_cnt    (lost_cnt),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Bench-side cycle stamp: value the DUT timestamp counter holds at each edge.
  int unsigned tb_cyc = 0;
  always @(posedge clk) tb_cyc <= reset ? tb_cyc + 1 : 0;

  // ---------------- behavioural model ----------------
  bit          started = 0;
  int unsigned m_cnt;
  bit          m_armed, m_dead, m_valid;
  int          m_peak, m_dead_left, m_above, m_amp, m_lost, bl_acc;
  int unsigned m_pts, m_ts;

  always @(posedge clk) begin
    int e;
    bit emit, lose;
    if (!reset) begin
      m_cnt = 0; m_armed = 0; m_dead = 0; m_valid = 0;
      m_peak = 0; m_pts = 0; m_dead_left = 0; m_above = 0;
      m_amp = 0; m_ts = 0; m_lost = 0; bl_acc = 0;
    end else begin
      e = int'(filter_data) - bl_acc / (1 << BL_SHIFT_DEF);
      if (e < 0) e = 0;
      emit = 0;
      lose = 0;
      if (m_armed) begin
        if (e <= int'(threshold)) begin
          emit = 1; m_armed = 0; m_dead = 1; m_dead_left = int'(holdoff);
        end else if (m_above == MAXW) begin
          lose = 1; m_armed = 0; m_dead = 1; m_dead_left = int'(holdoff);
        end else begin
          m_above++;
          if (e > m_peak) begin m_peak = e; m_pts = m_cnt; end
        end
      end else if (m_dead) begin
        if (m_dead_left > 0) m_dead_left--;
        else if (e <= int'(threshold)) m_dead = 0;
      end else begin
`ifdef PEAK_DET_BASELINE_EN
        bl_acc = bl_acc + int'(filter_data) - bl_acc / (1 << BL_SHIFT_DEF);
`endif
        if (e > int'(threshold)) begin
          m_armed = 1; m_peak = e; m_pts = m_cnt; m_above = 1;
        end
      end
      if (emit) begin
        if (!m_valid || out_ready) begin
          m_valid = 1; m_amp = m_peak; m_ts = m_pts;
        end else begin
          lose = 1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (lose && m_lost < 65535) m_lost++;
      m_cnt++;
    end
    started = 1;
  end

  // ---------------- per-cycle compare ----------------
  int ev_cnt = 0;
  always @(negedge clk) begin
    if (started) begin
      check("model_out_valid", out_valid, m_valid);
      check("model_busy", busy, m_armed || m_dead);
      check("model_lost_cnt", lost_cnt, m_lost);
      if (m_valid) begin
        check("model_out_amp", out_amp, m_amp);
        check("model_out_ts", out_ts, m_ts);
      end
      if (out_valid && out_ready) ev_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int v);
    filter_data = W'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic step_ts(input int v, output int unsigned stamp);
    filter_data = W'(v);
    stamp = tb_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    filter_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_lost_cnt", lost_cnt, 0);
    check("rst_out_amp", out_amp, 0);
    check("rst_out_ts", out_ts, 0);
    reset = 1'b1;
    ev_cnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned s;

    // Basic pulse, consumer always ready.
    threshold = 16'd100; holdoff = 8'd4; out_ready = 1'b1;
    do_reset();
    step(0); step(50); step(150); step_ts(300, s); step(250);
    check("t1_valid_before_end", out_valid, 0);
    step(90);
    check("t1_valid", out_valid, 1);
    check("t1_amp", out_amp, 300);
    check("t1_ts", out_ts, s);
    check("t1_busy", busy, 1);
    idle(8);
    check("t1_events", ev_cnt, 1);
    check("t1_idle", busy, 0);

    // Plateau: first sample of the flat top keeps the stamp.
    do_reset();
    step(0); step_ts(200, s); step(200); step(200); step(0);
    check("t2_amp", out_amp, 200);
    check("t2_ts_first", out_ts, s);
    idle(8);

    // Occupied slot: second event dropped, slot drains once ready.
    do_reset();
    out_ready = 1'b0;
    step(300); step(0);
    check("t3_first_valid", out_valid, 1);
    check("t3_first_amp", out_amp, 300);
    idle(8);
    step(400); step(0);
    check("t3_amp_kept", out_amp, 300);
    check("t3_lost", lost_cnt, 1);
    check("t3_still_valid", out_valid, 1);
    idle(3);
    out_ready = 1'b1;
    step(0);
    check("t3_freed", out_valid, 0);
    check("t3_events", ev_cnt, 1);

    // Over-long pulse is aborted.
    do_reset();
    for (int i = 0; i < MAXW + 5; i++) step(500);
    check("t4_no_event", out_valid, 0);
    check("t4_lost", lost_cnt, 1);
    check("t4_busy_high", busy, 1);
    step(0);
    check("t4_busy_low", busy, 0);
    check("t4_events", ev_cnt, 0);

    // Pulse inside the dead time is ignored.
    do_reset();
    holdoff = 8'd4;
    step(300); step(0); step(0); step(300); step(300);
    check("t5_dead_busy", busy, 1);
    step(0);
    idle(8);
    check("t5_events", ev_cnt, 1);
    check("t5_lost", lost_cnt, 0);

    // holdoff = 0 -> exactly one DEAD cycle.
    do_reset();
    holdoff = 8'd0;
    step(300); step(0);
    check("t6_dead_one", busy, 1);
    step(0);
    check("t6_back_idle", busy, 0);
    check("t6_events", ev_cnt, 1);

    // Reset mid-pulse with a pending event.
    do_reset();
    holdoff = 8'd4; out_ready = 1'b0;
    step(300); step(0);
    idle(8);
    step(300);
    check("t7_armed", busy, 1);
    check("t7_pending", out_valid, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("t7_rst_busy", busy, 0);
    check("t7_rst_valid", out_valid, 0);
    check("t7_rst_lost", lost_cnt, 0);
    reset = 1'b1;
    out_ready = 1'b1;
    idle(4);

`ifdef PEAK_DET_BASELINE_EN
    // Baseline settles on a constant 1000; a +40 pulse is then detected.
    do_reset();
    threshold = 16'hFFFF;
    for (int i = 0; i < 1500; i++) step(1000);
    threshold = 16'd30;
    step(1040); step(1040); step(1040); step(1000);
    check("t8_valid", out_valid, 1);
    check("t8_amp_near_40", (out_amp >= 38 && out_amp <= 41), 1);
    idle(8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pulse_peak_detector
